// File: rtl/error_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : error_monitor_pkg
//  Description : Shared types and default widths for the error_monitor
//                streaming result checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package error_monitor_pkg;

  // Default widths for the sample datapath and the accumulators
  localparam int DEF_DATA_BITS = 16;
  localparam int DEF_SUM_BITS  = 32;
  localparam int DEF_CNT_BITS  = 16;

  // Default tolerance: abs error strictly above this counts as a fail
  localparam int DEF_TOL       = 2;

  // Run-control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/error_monitor_abs_error.sv
`default_nettype none
// ============================================================================
//  Module      : abs_error
//  Description : Combinational absolute difference of two two's-complement
//                samples. The difference wraps modulo 2^DATA_BITS; a wrapped
//                difference equal to the most-negative value saturates to the
//                largest positive value so the result MSB is always zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module abs_error
  import error_monitor_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] ref_s,
  input  logic [DATA_BITS-1:0] dut_s,
  output logic [DATA_BITS-1:0] abs_err
);

  localparam logic [DATA_BITS-1:0] MOST_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [DATA_BITS-1:0] MAX_POS  = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic [DATA_BITS-1:0] ONE      = {{(DATA_BITS-1){1'b0}}, 1'b1};

  logic [DATA_BITS-1:0] diff;

  // Wrapped difference, then magnitude with most-negative saturation
  always_comb begin
    diff = ref_s - dut_s;
    if (!diff[DATA_BITS-1]) begin
      abs_err = diff;
    end else if (diff == MOST_NEG) begin
      abs_err = MAX_POS;
    end else begin
      abs_err = ~diff + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/error_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : error_monitor
//  Description : Streaming result checker. Accepts (reference, DUT) sample
//                pairs over valid/ready, computes the absolute error of each
//                pair in a two-stage pipeline, accumulates max / saturating
//                sum / count / fail count, and presents one result record on
//                a valid/ready result port at the end of each run.
//                Optional feature macro: ERROR_MONITOR_FIRST_FAIL_EN adds
//                res_first_fail_idx (index of the first out-of-tolerance pair).
//  Revision    : 1.0 - initial release
// ============================================================================
module error_monitor
  import error_monitor_pkg::*;
#(
  parameter int                   DATA_BITS = DEF_DATA_BITS,
  parameter int                   SUM_BITS  = DEF_SUM_BITS,
  parameter int                   CNT_BITS  = DEF_CNT_BITS,
  parameter logic [DATA_BITS-1:0] TOL       = DATA_BITS'(DEF_TOL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_ref,
  input  logic [DATA_BITS-1:0] in_dut,
  input  logic                 in_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_BITS-1:0] res_max_err,
  output logic [SUM_BITS-1:0]  res_sum_err,
  output logic [CNT_BITS-1:0]  res_count,
  output logic [CNT_BITS-1:0]  res_fail_count,
  output logic                 res_overflow,
  output logic                 busy
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
  ,
  output logic [CNT_BITS-1:0]  res_first_fail_idx
`endif
);

  // Adder width wide enough for either operand plus a carry, so the sum
  // saturation works even when SUM_BITS is narrower than DATA_BITS.
  localparam int AW = ((SUM_BITS > DATA_BITS) ? SUM_BITS : DATA_BITS) + 1;

  localparam logic [SUM_BITS-1:0] SUM_MAX = {SUM_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_nxt;

  logic                 accept;
  logic                 run_clear;
  logic [DATA_BITS-1:0] abs_w;

  logic                 s1_valid;
  logic [DATA_BITS-1:0] s1_abs;

  logic [AW-1:0]        sum_wide;
  logic                 sum_clamp;
  logic [SUM_BITS-1:0]  sum_next;
  logic                 is_fail;
  logic                 cnt_full;
  logic                 fail_full;

  assign accept    = in_valid & in_ready;
  assign run_clear = (state == ST_IDLE) & start;

  // --------------------------------------------------------------------------
  // Stage 1: absolute error of the incoming pair
  // --------------------------------------------------------------------------
  abs_error #(
    .DATA_BITS (DATA_BITS)
  ) u_abs_error (
    .ref_s   (in_ref),
    .dut_s   (in_dut),
    .abs_err (abs_w)
  );

  // Stage-1 register: captures the abs error of each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_abs   <= '0;
    end else if (run_clear) begin
      s1_valid <= 1'b0;
      s1_abs   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_abs <= abs_w;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: fold the stage-1 result into the run statistics
  // --------------------------------------------------------------------------

  // Saturating sum and counter-full detection for the fold
  always_comb begin
    sum_wide  = AW'(res_sum_err) + AW'(s1_abs);
    sum_clamp = (sum_wide > AW'(SUM_MAX));
    sum_next  = sum_clamp ? SUM_MAX : sum_wide[SUM_BITS-1:0];
    is_fail   = (s1_abs > TOL);
    cnt_full  = (res_count == CNT_MAX);
    fail_full = (res_fail_count == CNT_MAX);
  end

  // Statistics registers; they double as the held result record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_max_err    <= '0;
      res_sum_err    <= '0;
      res_count      <= '0;
      res_fail_count <= '0;
      res_overflow   <= 1'b0;
    end else if (run_clear) begin
      res_max_err    <= '0;
      res_sum_err    <= '0;
      res_count      <= '0;
      res_fail_count <= '0;
      res_overflow   <= 1'b0;
    end else if (s1_valid) begin
      // Ties keep the old maximum (strict unsigned compare)
      if (s1_abs > res_max_err) begin
        res_max_err <= s1_abs;
      end
      res_sum_err <= sum_next;
      if (!cnt_full) begin
        res_count <= res_count + CNT_ONE;
      end
      if (is_fail && !fail_full) begin
        res_fail_count <= res_fail_count + CNT_ONE;
      end
      // Sticky: set whenever a true value no longer fits its register
      if (sum_clamp || cnt_full || (is_fail && fail_full)) begin
        res_overflow <= 1'b1;
      end
    end
  end

`ifdef ERROR_MONITOR_FIRST_FAIL_EN
  logic first_found;

  // Record the pre-increment count of the first failing pair as its index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_first_fail_idx <= CNT_MAX;
      first_found        <= 1'b0;
    end else if (run_clear) begin
      res_first_fail_idx <= CNT_MAX;
      first_found        <= 1'b0;
    end else if (s1_valid && is_fail && !first_found) begin
      res_first_fail_idx <= res_count;
      first_found        <= 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Run-control FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; DRAIN lasts one cycle so the final
  // stage-1 result is folded before the record is presented.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_error_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_error_monitor
//  Description : Self-checking bench for error_monitor. Two instances (default
//                widths and a narrow-counter build) share one stimulus stream;
//                a run-level reference model predicts each result record from
//                the list of accepted pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_error_monitor;

  localparam int DW  = 16;
  localparam int SW  = 32;
  localparam int CW  = 16;
  localparam int SSW = 7;
  localparam int SCW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] in_ref = '0;
  logic [DW-1:0] in_dut = '0;

  logic           in_ready_a, res_valid_a, ovf_a, busy_a;
  logic [DW-1:0]  max_a;
  logic [SW-1:0]  sum_a;
  logic [CW-1:0]  cnt_a, fail_a;
  logic           in_ready_b, res_valid_b, ovf_b, busy_b;
  logic [DW-1:0]  max_b;
  logic [SSW-1:0] sum_b;
  logic [SCW-1:0] cnt_b, fail_b;
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
  logic [CW-1:0]  ff_a;
  logic [SCW-1:0] ff_b;
`endif

  error_monitor #(.DATA_BITS(DW), .SUM_BITS(SW), .CNT_BITS(CW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_ref(in_ref), .in_dut(in_dut), .in_last(in_last),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_max_err(max_a),
    .res_sum_err(sum_a), .res_count(cnt_a), .res_fail_count(fail_a),
    .res_overflow(ovf_a), .busy(busy_a)
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
    , .res_first_fail_idx(ff_a)
`endif
  );

  error_monitor #(.DATA_BITS(DW), .SUM_BITS(SSW), .CNT_BITS(SCW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_ref(in_ref), .in_dut(in_dut), .in_last(in_last),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_max_err(max_b),
    .res_sum_err(sum_b), .res_count(cnt_b), .res_fail_count(fail_b),
    .res_overflow(ovf_b), .busy(busy_b)
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
    , .res_first_fail_idx(ff_b)
`endif
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int bad_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: tracks run phase, collects abs errors of accepted pairs,
  // and computes the record from the whole list when the run ends.
  // --------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_REPORT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      q[$];
  int      e_max;
  longint  e_sum  [2];
  longint  e_cnt  [2];
  longint  e_fail [2];
  bit      e_ovf  [2];
  longint  e_ff   [2];

  function automatic int mabs(input logic [DW-1:0] r, input logic [DW-1:0] d);
    logic [DW-1:0] w;
    int v;
    w = r - d;
    v = int'($signed(w));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic void compute_record();
    for (int k = 0; k < 2; k++) begin
      longint smax, cmax, s;
      int m, f, firstf;
      smax = (longint'(1) << ((k == 0) ? SW : SSW)) - 1;
      cmax = (longint'(1) << ((k == 0) ? CW : SCW)) - 1;
      s = 0; m = 0; f = 0; firstf = -1;
      foreach (q[i]) begin
        if (q[i] > m) m = q[i];
        s += q[i];
        if (q[i] > 2) begin
          f++;
          if (firstf < 0) firstf = i;
        end
      end
      e_max     = m;
      e_sum[k]  = lmin(s, smax);
      e_cnt[k]  = lmin(q.size(), cmax);
      e_fail[k] = lmin(f, cmax);
      e_ovf[k]  = (s > smax) || (q.size() > cmax) || (f > cmax);
      e_ff[k]   = (firstf < 0) ? cmax : lmin(firstf, cmax);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = M_IDLE;
      q.delete();
      e_max = 0;
      for (int k = 0; k < 2; k++) begin
        e_sum[k] = 0; e_cnt[k] = 0; e_fail[k] = 0; e_ovf[k] = 0;
        e_ff[k] = (longint'(1) << ((k == 0) ? CW : SCW)) - 1;
      end
    end else begin
      case (m_phase)
        M_IDLE:   if (start) begin m_phase = M_RUN; q.delete(); end
        M_RUN:    if (in_valid) begin
                    q.push_back(mabs(in_ref, in_dut));
                    if (in_last) m_phase = M_DRAIN;
                  end
        M_DRAIN:  begin compute_record(); m_phase = M_REPORT; end
        M_REPORT: if (res_ready) m_phase = M_IDLE;
        default:  m_phase = M_IDLE;
      endcase
    end
  end

  // Every cycle: handshake/status against the model phase; the record
  // whenever it is meant to be held (IDLE after reset/report, REPORT).
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_a", in_ready_a, m_phase == M_RUN);
      chk("in_ready_b", in_ready_b, m_phase == M_RUN);
      chk("busy_a", busy_a, m_phase != M_IDLE);
      chk("busy_b", busy_b, m_phase != M_IDLE);
      chk("res_valid_a", res_valid_a, m_phase == M_REPORT);
      chk("res_valid_b", res_valid_b, m_phase == M_REPORT);
      if (m_phase == M_IDLE || m_phase == M_REPORT) begin
        chk("max_a", max_a, e_max);
        chk("max_b", max_b, e_max);
        chk("sum_a", sum_a, e_sum[0]);
        chk("sum_b", sum_b, e_sum[1]);
        chk("count_a", cnt_a, e_cnt[0]);
        chk("count_b", cnt_b, e_cnt[1]);
        chk("fail_a", fail_a, e_fail[0]);
        chk("fail_b", fail_b, e_fail[1]);
        chk("ovf_a", ovf_a, e_ovf[0]);
        chk("ovf_b", ovf_b, e_ovf[1]);
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
        chk("first_fail_a", ff_a, e_ff[0]);
        chk("first_fail_b", ff_b, e_ff[1]);
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] d,
                      input logic l, input int gap);
    int g;
    repeat (gap) begin
      in_valid = 1'b0;
      in_ref   = DW'($urandom);
      in_dut   = DW'($urandom);
      in_last  = 1'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_ref   = r;
    in_dut   = d;
    in_last  = l;
    g = 0;
    while (in_ready_a !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    if (in_ready_a !== 1'b1) chk("in_ready_timeout", in_ready_a, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int g = 0;
    while (res_valid_a !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    if (res_valid_a !== 1'b1) chk("res_valid_timeout", res_valid_a, 1);
  endtask

  task automatic drain(input int hold, input bit poke);
    res_ready = 1'b0;
    repeat (hold) begin
      if (poke) start = 1'($urandom);
      in_valid = 1'($urandom);
      tick();
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] r, d;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset mid-run, start asserted together with reset
    do_start();
    send(16'd1, 16'd0, 1'b0, 0);
    send(16'd2, 16'd9, 1'b0, 0);
    send(16'd3, 16'd3, 1'b0, 0);
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_res_valid", res_valid_a, 0);
    chk("rst_count", cnt_a, 0);
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("start_with_rst_ignored", busy_a, 0);
    do_start();
    send(16'd5, 16'd5, 1'b1, 0);
    wait_valid();
    chk("t1_count", cnt_a, 1);
    chk("t1_max", max_a, 0);
    chk("t1_sum", sum_a, 0);
    chk("t1_fail", fail_a, 0);
    drain(0, 0);

    // Mixed signs, latency of the record
    do_start();
    send(16'd10, 16'd7, 1'b0, 0);
    send(16'hFFFC, 16'd3, 1'b0, 1);
    send(16'd0, 16'd0, 1'b1, 0);
    chk("t2_lat1_valid", res_valid_a, 0);
    tick();
    chk("t2_lat2_valid", res_valid_a, 1);
    chk("t2_max", max_a, 7);
    chk("t2_sum", sum_a, 10);
    chk("t2_count", cnt_a, 3);
    chk("t2_fail", fail_a, 2);
    chk("t2_ovf", ovf_a, 0);
    drain(0, 0);

    // Extreme differences and most-negative saturation
    do_start();
    send(16'h8000, 16'h0001, 1'b0, 0);
    send(16'h0000, 16'h8000, 1'b1, 0);
    wait_valid();
    chk("t3_max", max_a, 32767);
    chk("t3_sum", sum_a, 65534);
    chk("t3_sum_narrow", sum_b, 127);
    chk("t3_ovf_narrow", ovf_b, 1);
    chk("t3_ovf", ovf_a, 0);
    drain(0, 0);

    // Sparse valid, held record with back-pressure and ignored start
    do_start();
    for (int i = 0; i < 6; i++) send(16'(i * 3), 16'd1, 1'b0 || (i == 5), 1);
    wait_valid();
    drain(5, 1);
    chk("t4_idle_after", busy_a, 0);

    // Counter saturation on the narrow build
    do_start();
    for (int i = 0; i < 20; i++) send(16'd9, 16'd0, i == 19, 0);
    wait_valid();
    chk("t5_count_narrow", cnt_b, 15);
    chk("t5_fail_narrow", fail_b, 15);
    chk("t5_ovf_narrow", ovf_b, 1);
    chk("t5_count", cnt_a, 20);
    chk("t5_sum", sum_a, 180);
    drain(0, 0);

    // First-fail index
    do_start();
    send(16'd0, 16'd0, 1'b0, 0);
    send(16'd1, 16'd0, 1'b0, 0);
    send(16'd5, 16'd0, 1'b0, 0);
    send(16'd9, 16'd0, 1'b1, 0);
    wait_valid();
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
    chk("t6_first_fail", ff_a, 2);
`endif
    chk("t6_fail", fail_a, 2);
    drain(0, 0);
    do_start();
    send(16'd3, 16'd1, 1'b0, 0);
    send(16'd7, 16'd9, 1'b1, 0);
    wait_valid();
`ifdef ERROR_MONITOR_FIRST_FAIL_EN
    chk("t6_first_fail_none", ff_a, 16'hFFFF);
`endif
    chk("t6_fail_none", fail_a, 0);
    drain(1, 0);

    // Randomized runs
    for (int run = 0; run < 12; run++) begin
      n = $urandom_range(1, 12);
      do_start();
      for (int i = 0; i < n; i++) begin
        r = DW'($urandom);
        if ($urandom_range(0, 1) == 0) d = r + DW'($urandom_range(0, 8)) - DW'(4);
        else d = DW'($urandom);
        send(r, d, i == n - 1, $urandom_range(0, 2));
      end
      wait_valid();
      drain($urandom_range(0, 3), 1'($urandom));
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
`default_nettype wire
